// File: rtl/freq_meter_gated.sv
// freq_meter_gated: counts synchronised Fxin rising edges over a Clk gate window.
// Define FREQ_METER_SATURATE_EN for a saturating edge counter driving Overflow.
module freq_meter_gated #(
   parameter int CNT_WIDTH   = 32,
   parameter int GATE_CYCLES = 50000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Fxin,
   input  logic                 Start,
   input  logic                 Continuous,
   output logic [CNT_WIDTH-1:0] Frequency,
   output logic                 Valid,
   output logic                 Busy,
   output logic                 Overflow
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      GATE,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_pulse;
   logic [GW-1:0]          gate_q, gate_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [CNT_WIDTH-1:0]   freq_q, freq_d;
   logic                   ovf_q, ovf_d, ovf_inc;
   logic                   oflag_q, oflag_d;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Fxin};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef FREQ_METER_SATURATE_EN
   always_comb begin
      cnt_inc = cnt_q;
      ovf_inc = ovf_q;
      if (edge_pulse) begin
         if (&cnt_q) begin
            ovf_inc = 1'b1;
         end else begin
            cnt_inc = cnt_q + CNT_WIDTH'(1);
         end
      end
   end
`else
   assign cnt_inc = cnt_q + CNT_WIDTH'(edge_pulse);
   assign ovf_inc = 1'b0;
`endif

   // The final gate cycle's pulse is folded into the latched result.
   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      freq_d  = freq_q;
      oflag_d = oflag_q;
      unique case (state_q)
         IDLE: begin
            if (Start || Continuous) begin
               state_d = GATE;
               gate_d  = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         GATE: begin
            cnt_d = cnt_inc;
            ovf_d = ovf_inc;
            if (gate_q == GATE_LAST) begin
               state_d = DONE;
               freq_d  = cnt_inc;
               oflag_d = ovf_inc;
            end else begin
               gate_d = gate_q + GW'(1);
            end
         end
         DONE: begin
            if (Continuous) begin
               state_d = GATE;
               gate_d  = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         gate_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         freq_q  <= '0;
         oflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         freq_q  <= freq_d;
         oflag_q <= oflag_d;
      end
   end

   assign Frequency = freq_q;
   assign Overflow  = oflag_q;
   assign Valid     = (state_q == DONE);
   assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter_gated.sv
// tb_freq_meter_gated: directed windows against a window-level edge-count model.
// Runs a 32-bit and a 4-bit counter instance side by side on the same stimulus.
module tb_freq_meter_gated;

   localparam int G = 100;
   localparam int S = 2;
   localparam int HMAX = 8191;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Fxin = 1'b0;
   logic        Start = 1'b0;
   logic        Continuous = 1'b0;
   logic [31:0] freq;
   logic        valid, busy, ovf;
   logic [3:0]  freq4;
   logic        valid4, busy4, ovf4;

   int vectors = 0;
   int errors = 0;
   int vcnt = 0;

   freq_meter_gated #(
      .CNT_WIDTH(32), .GATE_CYCLES(G), .SYNC_STAGES(S)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Fxin(Fxin), .Start(Start),
      .Continuous(Continuous), .Frequency(freq), .Valid(valid),
      .Busy(busy), .Overflow(ovf)
   );

   freq_meter_gated #(
      .CNT_WIDTH(4), .GATE_CYCLES(G), .SYNC_STAGES(S)
   ) dut4 (
      .Clk(Clk), .Rst_n(Rst_n), .Fxin(Fxin), .Start(Start),
      .Continuous(Continuous), .Frequency(freq4), .Valid(valid4),
      .Busy(busy4), .Overflow(ovf4)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   // Fxin: square wave of period per (per = 0 holds level lvl)
   int per = 0;
   bit lvl = 1'b0;
   int ph = 0;
   always @(posedge Clk) begin
      #1;
      if (per == 0) begin
         Fxin = lvl;
      end else begin
         ph = (ph + 1) % per;
         Fxin = (ph < per / 2);
      end
   end

   // Window model: an Fxin rise sampled at edge j is counted at edge j+S,
   // so a window started at edge t counts rises sampled in [t+1-S, t+G-S].
   int          cyc = 10;
   bit          h[0:HMAX];
   int          ws = -1;
   logic [31:0] e_freq = '0;
   logic        e_valid = 1'b0, e_busy = 1'b0, e_ovf = 1'b0;
   logic [3:0]  e_f4 = '0;
   logic        e_o4 = 1'b0;

   always @(posedge Clk) begin
      int c;
      if (cyc < HMAX) cyc++;
      h[cyc] = Rst_n ? Fxin : 1'b0;
      if (!Rst_n) begin
         ws = -1;
         e_valid = 1'b0; e_busy = 1'b0;
         e_freq = '0; e_ovf = 1'b0;
         e_f4 = '0; e_o4 = 1'b0;
      end else if (ws >= 0 && cyc == ws + G) begin
         c = 0;
         for (int j = ws + 1 - S; j <= ws + G - S; j++)
            if (h[j] && !h[j-1]) c++;
         e_freq = c;
         e_ovf = 1'b0;
`ifdef FREQ_METER_SATURATE_EN
         e_f4 = (c > 15) ? 4'd15 : 4'(c);
         e_o4 = (c > 15);
`else
         e_f4 = 4'(c % 16);
         e_o4 = 1'b0;
`endif
         e_valid = 1'b1;
         e_busy = 1'b1;
      end else if (ws >= 0 && cyc == ws + G + 1) begin
         e_valid = 1'b0;
         if (Continuous) begin
            ws = cyc;
            e_busy = 1'b1;
         end else begin
            ws = -1;
            e_busy = 1'b0;
         end
      end else if (ws < 0 && (Start || Continuous)) begin
         ws = cyc;
         e_busy = 1'b1;
      end
   end

   always @(negedge Clk) begin
      if (valid) vcnt++;
      if (Rst_n) begin
         chk("valid", valid, e_valid);
         chk("busy", busy, e_busy);
         chk("freq", freq, e_freq);
         chk("ovf", ovf, e_ovf);
         chk("valid4", valid4, e_valid);
         chk("busy4", busy4, e_busy);
         chk("freq4", freq4, e_f4);
         chk("ovf4", ovf4, e_o4);
      end else begin
         chk("rst_valid", valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_freq", freq, 0);
         chk("rst_ovf", ovf, 0);
         chk("rst_freq4", freq4, 0);
         chk("rst_ovf4", ovf4, 0);
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge Clk);
      #1;
   endtask

   task automatic start_pulse();
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
   endtask

   task automatic wait_valid(inout int n, input int lim);
      @(negedge Clk);
      while (!valid && n < lim) begin
         @(posedge Clk);
         n++;
         @(negedge Clk);
      end
      if (!valid) begin
         vectors++;
         errors++;
         $display("FAIL wait_valid: no Valid after %0d cycles, required by %0d",
                  n, lim);
      end
   endtask

   initial begin
      int n, vc;
      tick(3);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("init_freq", freq, 0);
      chk("init_busy", busy, 0);

      // single window, period 10
      per = 10;
      tick(5);
      start_pulse();
      n = 1;
      wait_valid(n, 300);
      chk("t1_latency", n, 101);
      chk("t1_freq", freq, 10);
      chk("t1_freq4", freq4, 10);
      chk("t1_ovf", ovf, 0);
      tick(3);
      @(negedge Clk);
      chk("t1_busy_after", busy, 0);
      chk("t1_hold", freq, 10);

      // continuous, period 5
      per = 5;
      tick(5);
      Continuous = 1'b1;
      n = 0;
      wait_valid(n, 300);
      @(posedge Clk);
      n = 1;
      wait_valid(n, 300);
      chk("t2_interval", n, 101);
      chk("t2_freq", freq, 20);
`ifdef FREQ_METER_SATURATE_EN
      chk("t2_freq4", freq4, 15);
      chk("t2_ovf4", ovf4, 1);
`else
      chk("t2_freq4", freq4, 4);
      chk("t2_ovf4", ovf4, 0);
`endif
      tick(50);
      Continuous = 1'b0;
      n = 0;
      wait_valid(n, 300);
      chk("t2_last_freq", freq, 20);
      tick(3);
      @(negedge Clk);
      chk("t2_busy_after", busy, 0);

      // 25 edges per window into the 4-bit counter
      per = 4;
      tick(8);
      start_pulse();
      n = 1;
      wait_valid(n, 300);
      chk("t3_freq", freq, 25);
`ifdef FREQ_METER_SATURATE_EN
      chk("t3_freq4", freq4, 15);
      chk("t3_ovf4", ovf4, 1);
`else
      chk("t3_freq4", freq4, 9);
      chk("t3_ovf4", ovf4, 0);
`endif

      // reset mid-window
      tick(3);
      start_pulse();
      tick(49);
      vc = vcnt;
      Rst_n = 1'b0;
      #1;
      chk("t4_freq_async", freq, 0);
      chk("t4_busy_async", busy, 0);
      chk("t4_valid_async", valid, 0);
      chk("t4_ovf4_async", ovf4, 0);
      tick(2);
      Rst_n = 1'b1;
      tick(150);
      chk("t4_no_valid", vcnt - vc, 0);
      chk("t4_idle", busy, 0);

      // Fxin stuck high, Start re-pulsed mid-window
      per = 0;
      lvl = 1'b1;
      tick(10);
      vc = vcnt;
      start_pulse();
      tick(30);
      start_pulse();
      n = 32;
      wait_valid(n, 300);
      chk("t5_latency", n, 101);
      chk("t5_freq", freq, 0);
      tick(150);
      chk("t5_one_valid", vcnt - vc, 1);
      chk("t5_idle", busy, 0);

      // Fxin stuck low
      lvl = 1'b0;
      tick(10);
      start_pulse();
      n = 1;
      wait_valid(n, 300);
      chk("t6_freq", freq, 0);
      chk("t6_freq4", freq4, 0);

      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
